// File: rtl/lfsr_pkg.sv
// Shared LFSR helpers for randomizer/lfsr_checker: XAPP052 tap table, the
// Galois XNOR step with all-ones lockup escape, and the checker state encoding.
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  // Bit 0 is never a tap, so 0 doubles as "unused slot".
  function automatic logic [63:0] tap_bits(input int unsigned a, input int unsigned b = 0,
                                           input int unsigned c = 0, input int unsigned d = 0,
                                           input int unsigned e = 0);
    logic [63:0] t;
    t = 64'd0;
    t[a] = 1'b1;
    t[b] = 1'b1;
    t[c] = 1'b1;
    t[d] = 1'b1;
    t[e] = 1'b1;
    t[0] = 1'b0;
    return t;
  endfunction

  function automatic logic [63:0] lfsr_tap(input int unsigned width);
    logic [63:0] t;
    case (width)
      3:  t = tap_bits(2);
      4:  t = tap_bits(3);
      5:  t = tap_bits(3);
      6:  t = tap_bits(5);
      7:  t = tap_bits(6);
      8:  t = tap_bits(6, 5, 4);
      9:  t = tap_bits(5);
      10: t = tap_bits(7);
      11: t = tap_bits(9);
      12: t = tap_bits(6, 4, 1);
      13: t = tap_bits(4, 3, 1);
      14: t = tap_bits(5, 3, 1);
      15: t = tap_bits(14);
      16: t = tap_bits(15, 13, 4);
      17: t = tap_bits(14);
      18: t = tap_bits(11);
      19: t = tap_bits(6, 2, 1);
      20: t = tap_bits(17);
      21: t = tap_bits(19);
      22: t = tap_bits(21);
      23: t = tap_bits(18);
      24: t = tap_bits(23, 22, 17);
      25: t = tap_bits(22);
      26: t = tap_bits(6, 2, 1);
      27: t = tap_bits(5, 2, 1);
      28: t = tap_bits(25);
      29: t = tap_bits(27);
      30: t = tap_bits(6, 4, 1);
      31: t = tap_bits(28);
      32: t = tap_bits(22, 2, 1);
      33: t = tap_bits(20);
      34: t = tap_bits(27, 2, 1);
      35: t = tap_bits(33);
      36: t = tap_bits(25);
      37: t = tap_bits(5, 4, 3, 2, 1);
      38: t = tap_bits(6, 5, 1);
      39: t = tap_bits(35);
      40: t = tap_bits(38, 21, 19);
      41: t = tap_bits(38);
      42: t = tap_bits(41, 20, 19);
      43: t = tap_bits(42, 38, 37);
      44: t = tap_bits(43, 18, 17);
      45: t = tap_bits(44, 42, 41);
      46: t = tap_bits(45, 26, 25);
      47: t = tap_bits(42);
      48: t = tap_bits(47, 21, 20);
      49: t = tap_bits(40);
      50: t = tap_bits(49, 24, 23);
      51: t = tap_bits(50, 36, 35);
      52: t = tap_bits(49);
      53: t = tap_bits(52, 38, 37);
      54: t = tap_bits(53, 18, 17);
      55: t = tap_bits(31);
      56: t = tap_bits(55, 35, 34);
      57: t = tap_bits(50);
      58: t = tap_bits(39);
      59: t = tap_bits(58, 38, 37);
      60: t = tap_bits(59);
      61: t = tap_bits(60, 46, 45);
      62: t = tap_bits(61, 6, 5);
      63: t = tap_bits(62);
      64: t = tap_bits(63, 61, 60);
      default: t = 64'd0;
    endcase
    return t;
  endfunction

  // Width-generic step on a 64-bit container; bits at and above width stay 0.
  function automatic logic [63:0] lfsr_next(input logic [63:0] cur, input logic [63:0] tap,
                                            input int unsigned width = 64);
    logic [63:0] nxt;
    logic [63:0] ones;
    nxt = 64'd0;
    for (int i = 1; i < 64; i++) begin
      if (i < width) begin
        nxt[i-1] = tap[i] ? ~(cur[i] ^ cur[0]) : cur[i];
      end else begin
        nxt[i-1] = nxt[i-1];
      end
    end
    nxt[width-1] = cur[0];
    ones = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    if (nxt == ones) begin
      nxt = 64'd0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single LFSR step next = f(cur), shared by randomizer and lfsr_checker.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] cur,
  output logic [W-1:0] next
);

  localparam logic [63:0] TAP_FULL = lfsr_tap(W);

  logic [W-1:0] raw_s;

  // XNOR Galois shift; the all-ones lockup state is folded onto zero.
  always_comb begin
    raw_s = '0;
    raw_s[W-1] = cur[0];
    for (int i = 1; i < W; i++) begin
      raw_s[i-1] = TAP_FULL[i] ? ~(cur[i] ^ cur[0]) : cur[i];
    end
    next = (&raw_s) ? '0 : raw_s;
  end

endmodule

// File: rtl/lfsr_checker.sv
// Time-multiplexed multichannel PRBS checker: HUNT/VERIFY/LOCKED per channel.
// Optional per-channel error counters are enabled by LFSR_CHECKER_ERR_CNT_EN.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int NR_CHANNELS   = 1,
  parameter int INPUT_WIDTH   = 32,
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_COUNT  = 4,
  parameter int ERR_CNT_WIDTH = 16,
  localparam int CH_W = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_W-1:0]          chk_ch,
  input  logic [INPUT_WIDTH-1:0]   chk_in,
  input  logic                     chk_in_valid,
  input  logic                     chk_clear,
  output logic                     chk_out_valid,
  output logic [CH_W-1:0]          chk_out_ch,
  output logic                     chk_match,
  output logic                     chk_locked,
  output logic [ERR_CNT_WIDTH-1:0] chk_err_cnt
);

  localparam int W      = INPUT_WIDTH;
  localparam int DEPTH  = 1 << CH_W;
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);
  localparam logic [CH_W:0]     NR_CH_V  = (CH_W + 1)'(NR_CHANNELS);
  localparam logic [RUN_W-1:0]  LOCK_V   = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
  localparam logic [MISS_W-1:0] UNLOCK_V = MISS_W'(UNLOCK_COUNT);
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

  // Arrays are sized to the full index range so any chk_ch reads safely.
  lfsr_state_e       state_r [DEPTH];
  logic [W-1:0]      pred_r  [DEPTH];
  logic [RUN_W-1:0]  run_r   [DEPTH];
  logic [MISS_W-1:0] miss_r  [DEPTH];

  logic              ch_ok_s, take_s, clear_s, match_s;
  lfsr_state_e       cur_state_s, eff_state_s, next_state_s;
  logic [W-1:0]      cur_pred_s, step_in_s, step_out_s;
  logic [RUN_W-1:0]  cur_run_s, next_run_s, run_inc_s;
  logic [MISS_W-1:0] cur_miss_s, next_miss_s, miss_inc_s;

  assign ch_ok_s     = ({1'b0, chk_ch} < NR_CH_V);
  assign take_s      = chk_in_valid && ch_ok_s;
  assign clear_s     = chk_clear && ch_ok_s;
  assign cur_state_s = state_r[chk_ch];
  assign cur_pred_s  = pred_r[chk_ch];
  assign cur_run_s   = run_r[chk_ch];
  assign cur_miss_s  = miss_r[chk_ch];
  assign eff_state_s = chk_clear ? HUNT : cur_state_s;
  assign match_s     = (eff_state_s != HUNT) && (chk_in == cur_pred_s);
  assign run_inc_s   = cur_run_s + RUN_ONE;
  assign miss_inc_s  = cur_miss_s + MISS_ONE;
  // Once locked the predictor free-runs so corrupt words cannot poison it.
  assign step_in_s   = (eff_state_s == LOCKED) ? cur_pred_s : chk_in;

  lfsr_step #(.W(W)) u_step (
    .cur  (step_in_s),
    .next (step_out_s)
  );

  // Next-state for the addressed channel.
  always_comb begin
    next_state_s = cur_state_s;
    next_run_s   = cur_run_s;
    next_miss_s  = cur_miss_s;
    if (take_s) begin
      case (eff_state_s)
        HUNT: begin
          next_state_s = VERIFY;
          next_run_s   = '0;
        end
        VERIFY: begin
          if (match_s) begin
            next_run_s = run_inc_s;
            if (run_inc_s == LOCK_V) begin
              next_state_s = LOCKED;
              next_miss_s  = '0;
            end else begin
              next_state_s = VERIFY;
            end
          end else begin
            next_run_s   = '0;
            next_state_s = VERIFY;
          end
        end
        LOCKED: begin
          if (match_s) begin
            next_miss_s = '0;
          end else begin
            next_miss_s = miss_inc_s;
            if (miss_inc_s == UNLOCK_V) begin
              next_state_s = HUNT;
            end else begin
              next_state_s = LOCKED;
            end
          end
        end
        default: next_state_s = HUNT;
      endcase
    end else if (clear_s) begin
      next_state_s = HUNT;
    end else begin
      next_state_s = cur_state_s;
    end
  end

  // Channel context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_r[i] <= HUNT;
        pred_r[i]  <= '0;
        run_r[i]   <= '0;
        miss_r[i]  <= '0;
      end
    end else if (take_s) begin
      state_r[chk_ch] <= next_state_s;
      pred_r[chk_ch]  <= step_out_s;
      run_r[chk_ch]   <= next_run_s;
      miss_r[chk_ch]  <= next_miss_s;
    end else if (clear_s) begin
      state_r[chk_ch] <= next_state_s;
    end else begin
      state_r[chk_ch] <= state_r[chk_ch];
    end
  end

  // Result registers, one pulse per accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_out_valid <= 1'b0;
      chk_out_ch    <= '0;
      chk_match     <= 1'b0;
      chk_locked    <= 1'b0;
    end else begin
      chk_out_valid <= take_s;
      if (take_s) begin
        chk_out_ch <= chk_ch;
        chk_match  <= match_s;
        chk_locked <= (next_state_s == LOCKED);
      end else begin
        chk_out_ch <= chk_out_ch;
      end
    end
  end

`ifdef LFSR_CHECKER_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_r [DEPTH];
  logic [ERR_CNT_WIDTH-1:0] err_base_s, err_next_s;
  logic                     err_inc_s;

  assign err_inc_s = take_s && (eff_state_s == LOCKED) && !match_s;

  // Saturating error count; a clear restarts it from zero.
  always_comb begin
    err_base_s = chk_clear ? '0 : err_r[chk_ch];
    if (err_inc_s && (err_base_s != {ERR_CNT_WIDTH{1'b1}})) begin
      err_next_s = err_base_s + ERR_CNT_WIDTH'(1);
    end else begin
      err_next_s = err_base_s;
    end
  end

  // Error counter storage and its output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        err_r[i] <= '0;
      end
      chk_err_cnt <= '0;
    end else if (take_s || clear_s) begin
      err_r[chk_ch] <= err_next_s;
      if (take_s) begin
        chk_err_cnt <= err_next_s;
      end else begin
        chk_err_cnt <= chk_err_cnt;
      end
    end else begin
      chk_err_cnt <= chk_err_cnt;
    end
  end
`else
  assign chk_err_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed scoreboard bench for lfsr_checker (W=8, 3 channels, lock/unlock 4).
module tb_lfsr_checker;

`ifdef LFSR_CHECKER_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int S_HUNT = 0, S_VER = 1, S_LOCK = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  chk_ch = 2'd0;
  logic [7:0]  chk_in = 8'd0;
  logic        chk_in_valid = 1'b0;
  logic        chk_clear = 1'b0;
  logic        chk_out_valid;
  logic [1:0]  chk_out_ch;
  logic        chk_match;
  logic        chk_locked;
  logic [15:0] chk_err_cnt;

  int n_tests = 0;
  int n_fail = 0;

  int          m_state [4];
  logic [7:0]  m_pred  [4];
  int          m_run   [4];
  int          m_miss  [4];
  logic [15:0] m_err   [4];
  logic [19:0] sb [$];

  lfsr_checker #(
    .NR_CHANNELS(3), .INPUT_WIDTH(8), .LOCK_COUNT(4), .UNLOCK_COUNT(4), .ERR_CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .chk_ch(chk_ch), .chk_in(chk_in),
    .chk_in_valid(chk_in_valid), .chk_clear(chk_clear),
    .chk_out_valid(chk_out_valid), .chk_out_ch(chk_out_ch), .chk_match(chk_match),
    .chk_locked(chk_locked), .chk_err_cnt(chk_err_cnt)
  );

  always #5 clk = ~clk;

  // W=8 XNOR Galois step, taps at bits 6,5,4.
  function automatic logic [7:0] f8(input logic [7:0] c);
    logic [7:0] n;
    n = {c[0], c[7], ~(c[6] ^ c[0]), ~(c[5] ^ c[0]), ~(c[4] ^ c[0]), c[3], c[2], c[1]};
    return (n == 8'hFF) ? 8'h00 : n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_state[i] = S_HUNT; m_pred[i] = 8'h00; m_run[i] = 0; m_miss[i] = 0; m_err[i] = 16'h0000;
    end
    sb.delete();
  endtask

  task automatic model_word(input logic [1:0] ch, input logic [7:0] w, input logic clr);
    logic m;
    m = 1'b0;
    if (clr) begin m_err[ch] = 16'h0000; m_state[ch] = S_HUNT; end
    case (m_state[ch])
      S_HUNT: begin m_pred[ch] = f8(w); m_run[ch] = 0; m_state[ch] = S_VER; end
      S_VER: begin
        if (w == m_pred[ch]) begin
          m = 1'b1; m_run[ch]++;
          if (m_run[ch] == 4) begin m_state[ch] = S_LOCK; m_miss[ch] = 0; end
        end else m_run[ch] = 0;
        m_pred[ch] = f8(w);
      end
      default: begin
        m = (w == m_pred[ch]);
        m_pred[ch] = f8(m_pred[ch]);
        if (m) m_miss[ch] = 0;
        else begin
          if (m_err[ch] != 16'hFFFF) m_err[ch]++;
          m_miss[ch]++;
          if (m_miss[ch] == 4) m_state[ch] = S_HUNT;
        end
      end
    endcase
    sb.push_back({ch, m, (m_state[ch] == S_LOCK), (ERR_EN ? m_err[ch] : 16'h0000)});
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] w, input logic clr);
    chk_ch = ch; chk_in = w; chk_in_valid = 1'b1; chk_clear = clr;
    if (ch < 2'd3) model_word(ch, w, clr);
    @(posedge clk); #1;
    chk_in_valid = 1'b0; chk_clear = 1'b0;
  endtask

  task automatic clear_only(input logic [1:0] ch);
    chk_ch = ch; chk_clear = 1'b1;
    m_err[ch] = 16'h0000; m_state[ch] = S_HUNT;
    @(posedge clk); #1;
    chk_clear = 1'b0;
  endtask

  // Scoreboard: every result pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && chk_out_valid) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected observed=%0h expected=none", {chk_out_ch, chk_match, chk_locked, chk_err_cnt});
      end
      if (sb.size() != 0) begin
        logic [19:0] e;
        e = sb.pop_front();
        n_tests++;
        assert ({chk_out_ch, chk_match, chk_locked, chk_err_cnt} === e) else begin
          n_fail++;
          $error("FAIL sb_result observed=%0h expected=%0h", {chk_out_ch, chk_match, chk_locked, chk_err_cnt}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w0, w1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {chk_out_valid, chk_out_ch, chk_match, chk_locked, chk_err_cnt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Seed 0x01 then correct continuation; lock on the fifth word.
    w0 = 8'h01;
    for (int i = 1; i <= 5; i++) begin
      send(2'd0, w0, 1'b0);
      if (i == 2) check("w2_in", {24'd0, w0}, 32'h80);
      if (i == 3) check("w3_in", {24'd0, w0}, 32'h78);
      if (i == 4) check("w4_match_lock", {chk_match, chk_locked}, 32'b10);
      if (i == 5) check("w5_match_lock", {chk_match, chk_locked}, 32'b11);
      w0 = f8(w0);
    end
    check("w5_err", chk_err_cnt, 32'd0);

    // Single corrupted word while locked.
    send(2'd0, w0 ^ 8'h01, 1'b0); w0 = f8(w0);
    check("corrupt1_match", chk_match, 32'd0);
    check("corrupt1_err", chk_err_cnt, ERR_EN ? 32'd1 : 32'd0);
    send(2'd0, w0, 1'b0); w0 = f8(w0);
    check("after_corrupt", {chk_match, chk_locked}, 32'b11);

    // Four consecutive corrupted words drop lock.
    for (int i = 0; i < 4; i++) begin
      send(2'd0, w0 ^ 8'h01, 1'b0); w0 = f8(w0);
    end
    check("unlock_state", chk_locked, 32'd0);
    check("unlock_err", chk_err_cnt, ERR_EN ? 32'd5 : 32'd0);
    for (int i = 1; i <= 5; i++) begin
      send(2'd0, w0, 1'b0); w0 = f8(w0);
      if (i == 4) check("relock_early", chk_locked, 32'd0);
    end
    check("relock", chk_locked, 32'd1);

    // Clear-only on ch0, then interleave ch0/ch1 with separate seeds.
    clear_only(2'd0);
    check("clear_no_pulse", chk_out_valid, 32'd0);
    w1 = 8'h5A;
    for (int i = 1; i <= 5; i++) begin
      send(2'd0, w0, 1'b0); w0 = f8(w0);
      if (i == 5) check("ch0_lock", chk_locked, 32'd1);
      send(2'd1, w1, 1'b0); w1 = f8(w1);
    end
    check("ch1_lock", {chk_out_ch, chk_locked}, 32'b011);
    send(2'd1, w1 ^ 8'h01, 1'b0); w1 = f8(w1);
    send(2'd0, w0, 1'b0); w0 = f8(w0);
    check("ch0_isolated", {chk_out_ch, chk_match, chk_locked, chk_err_cnt}, {14'd0, 2'd0, 1'b1, 1'b1, 16'd0});
    send(2'd1, w1 ^ 8'h01, 1'b0); w1 = f8(w1);
    send(2'd1, w1 ^ 8'h01, 1'b0); w1 = f8(w1);
    check("ch1_err3", {chk_locked, chk_err_cnt}, {15'd0, 1'b1, (ERR_EN ? 16'd3 : 16'd0)});

    // Clear together with a valid word: reseed and zero count.
    send(2'd1, w1, 1'b1); w1 = f8(w1);
    check("clear_valid", {chk_match, chk_locked, chk_err_cnt}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      send(2'd1, w1, 1'b0); w1 = f8(w1);
      if (i == 3) check("clear_relock_early", chk_locked, 32'd0);
    end
    check("clear_relock", chk_locked, 32'd1);

    // Out-of-range channel is ignored.
    send(2'd3, 8'h33, 1'b0);
    check("bad_ch_no_pulse", chk_out_valid, 32'd0);

    // Asynchronous reset mid-stream.
    send(2'd1, w1, 1'b0); w1 = f8(w1);
    check("pre_reset", {chk_out_valid, chk_locked}, 32'b11);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {chk_out_valid, chk_out_ch, chk_match, chk_locked, chk_err_cnt}, 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 5; i++) begin
      send(2'd1, w1, 1'b0); w1 = f8(w1);
      if (i == 1) check("post_reset_hunt", {chk_match, chk_locked}, 32'b00);
    end
    check("post_reset_lock", chk_locked, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
